// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver FSM states and channel/synchronizer constants
// common to the transmitter and receiver.
package i2s_pkg;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    RX_LEFT  = 2'd1,
    RX_RIGHT = 2'd2
  } rx_state_t;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 3;

  // Width of a counter that must hold values 0..max_val.
  function automatic int unsigned count_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/i2s_sync.sv
// N-flop synchronizer for one asynchronous I2S line, with an optional
// single-cycle rising-edge strobe on the synchronized value.
module i2s_sync #(
  parameter int unsigned STAGES   = 2,
  parameter bit          EDGE_DET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

  generate
    if (EDGE_DET) begin : g_edge
      logic q_d;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q_d <= 1'b0;
        end else begin
          q_d <= sync_q[STAGES-1];
        end
      end

      assign rise = sync_q[STAGES-1] & ~q_d;
    end else begin : g_plain
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: oversamples SCLK/WS/SD on clk, assembles {left,right} frames
// and presents them through a valid/ready output register.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SCLK,
  input  logic                  WS,
  input  logic                  SD,
  output logic [2*DWIDTH-1:0]   rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int unsigned CW = count_width(DWIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DWIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DWIDTH + 1);

  logic sclk_rise;
  logic ws_s;
  logic sd_s;
  logic ws_edge_unused;
  logic sd_edge_unused;
  logic sclk_s_unused;

  i2s_sync #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (SCLK),
    .q     (sclk_s_unused),
    .rise  (sclk_rise)
  );

  i2s_sync #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_ws (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (WS),
    .q     (ws_s),
    .rise  (ws_edge_unused)
  );

  i2s_sync #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_sd (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (SD),
    .q     (sd_s),
    .rise  (sd_edge_unused)
  );

  rx_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [DWIDTH-1:0]     word_q, word_d, word_next;
  logic [DWIDTH-1:0]     left_q, left_d;
  logic                  bad_q, bad_d;
  logic                  prev_ws_q, prev_ws_d;
  logic [2*DWIDTH-1:0]   frame_q, frame_d;
  logic                  done_q, done_d;
  logic                  ferr_d;
  logic                  ws_fall, ws_rise, word_ok;

  assign word_next = {word_q[DWIDTH-2:0], sd_s};
  assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  assign word_ok   = (cnt_inc == CNT_FULL);
  assign ws_fall   = (prev_ws_q == WS_RIGHT) && (ws_s == WS_LEFT);
  assign ws_rise   = (prev_ws_q == WS_LEFT)  && (ws_s == WS_RIGHT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      cnt_q     <= '0;
      word_q    <= '0;
      left_q    <= '0;
      bad_q     <= 1'b0;
      prev_ws_q <= 1'b0;
      frame_q   <= '0;
      done_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      left_q    <= left_d;
      bad_q     <= bad_d;
      prev_ws_q <= prev_ws_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      frame_err <= ferr_d;
    end
  end

  // The bit sampled on a WS change is the LSB of the word that just ended,
  // so each word close uses word_next/cnt_inc, not the registered values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    left_d    = left_q;
    bad_d     = bad_q;
    prev_ws_d = prev_ws_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;

    if (sclk_rise) begin
      prev_ws_d = ws_s;
      word_d    = word_next;
      cnt_d     = cnt_inc;

      unique case (state_q)
        HUNT: begin
          if (ws_fall) begin
            cnt_d   = '0;
            bad_d   = 1'b0;
            state_d = RX_LEFT;
          end
        end
        RX_LEFT: begin
          if (ws_rise) begin
            left_d  = word_next;
            bad_d   = !word_ok;
            ferr_d  = !word_ok;
            cnt_d   = '0;
            state_d = RX_RIGHT;
          end
        end
        RX_RIGHT: begin
          if (ws_fall) begin
            ferr_d  = !word_ok;
            if (word_ok && !bad_q) begin
              frame_d = {left_q, word_next};
              done_d  = 1'b1;
            end
            bad_d   = 1'b0;
            cnt_d   = '0;
            state_d = RX_LEFT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // A completing frame replaces an entry that is being accepted this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= done_q && rx_valid && !rx_ready;
      if (done_q && (!rx_valid || rx_ready)) begin
        rx_data  <= frame_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: an I2S transmitter model drives framed
// words and a consumer/monitor logs accepted frames and error pulses.
`timescale 1ns/1ps
module tb_i2s_receiver;

  localparam int unsigned DWIDTH      = 8;
  localparam int unsigned SYNC_STAGES = 2;

  logic                clk      = 1'b0;
  logic                rst_n    = 1'b0;
  logic                SCLK     = 1'b0;
  logic                WS       = 1'b0;
  logic                SD       = 1'b0;
  logic                rx_ready = 1'b0;
  logic [2*DWIDTH-1:0] rx_data;
  logic                rx_valid;
  logic                overrun;
  logic                frame_err;

  i2s_receiver #(.DWIDTH(DWIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SCLK      (SCLK),
    .WS        (WS),
    .SD        (SD),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: accepted frames, error pulse counts, valid-rise latency.
  int          cyc      = 0;
  int          rise_cyc = 0;
  int          lat_min  = 999;
  int          lat_max  = 0;
  bit          lat_en   = 1'b0;
  int          ovr_cnt  = 0;
  int          ferr_cnt = 0;
  logic        valid_d  = 1'b0;
  logic [15:0] acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
    if (overrun) ovr_cnt++;
    if (frame_err) ferr_cnt++;
    if (lat_en && rx_valid && !valid_d) begin
      if (cyc - rise_cyc < lat_min) lat_min = cyc - rise_cyc;
      if (cyc - rise_cyc > lat_max) lat_max = cyc - rise_cyc;
    end
    valid_d = rx_valid;
  end

  function automatic logic [15:0] get_acc(input int idx);
    if (idx < acc_q.size()) return acc_q[idx];
    return 16'hxxxx;
  endfunction

  // Transmitter model: SD is delayed one slot behind WS (I2S one-bit delay).
  int   half     = 4;
  logic sd_delay = 1'b0;
  bit   primed   = 1'b0;

  task automatic put_bit(input logic w, input logic b);
    SCLK = 1'b0;
    WS   = w;
    SD   = b;
    repeat (half) @(posedge clk);
    #1;
    SCLK     = 1'b1;
    rise_cyc = cyc;
    repeat (half) @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic w, input logic [7:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (primed) primed = 1'b0;
      else        put_bit(w, sd_delay);
      sd_delay = d[i];
    end
  endtask

  task automatic send_frame(input logic [7:0] l, input logic [7:0] r);
    put_word(1'b0, l, 8);
    put_word(1'b1, r, 8);
  endtask

  // Emits the next left-word start slot, delivering the pending right LSB.
  task automatic close_frame();
    put_bit(1'b0, sd_delay);
    primed = 1'b1;
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
    #1;
  endtask

  int          b_acc, b_ovr, b_ferr;
  logic [15:0] sent_q[$];
  logic [15:0] fr;

  task automatic take_base();
    b_acc  = acc_q.size();
    b_ovr  = ovr_cnt;
    b_ferr = ferr_cnt;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", 32'(rx_data), 32'h0);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Continuous frames, first one lost while hunting
    rx_ready = 1'b1;
    lat_en   = 1'b1;
    take_base();
    for (int f = 0; f < 4; f++) send_frame(8'hA5, 8'h3C);
    close_frame();
    settle();
    lat_en = 1'b0;
    check("stream_count", 32'(acc_q.size() - b_acc), 32'd3);
    for (int i = 0; i < 3; i++) check("stream_data", 32'(get_acc(b_acc + i)), 32'hA53C);
    check("latency_min", 32'(lat_min), 32'(SYNC_STAGES + 2));
    check("latency_max", 32'(lat_max), 32'(SYNC_STAGES + 2));
    check("stream_overrun", 32'(ovr_cnt - b_ovr), 32'd0);
    check("stream_frame_err", 32'(ferr_cnt - b_ferr), 32'd0);

    // Back-pressure: first frame held, next two dropped
    rx_ready = 1'b0;
    take_base();
    send_frame(8'h11, 8'h22);
    send_frame(8'h33, 8'h44);
    send_frame(8'h55, 8'h66);
    close_frame();
    settle();
    check("hold_valid", 32'(rx_valid), 32'h1);
    check("hold_data", 32'(rx_data), 32'h1122);
    check("hold_overrun", 32'(ovr_cnt - b_ovr), 32'd2);
    check("hold_frame_err", 32'(ferr_cnt - b_ferr), 32'd0);
    rx_ready = 1'b1;
    take_base();
    repeat (3) @(posedge clk);
    #1;
    check("drain_count", 32'(acc_q.size() - b_acc), 32'd1);
    check("drain_data", 32'(get_acc(b_acc)), 32'h1122);
    check("drain_valid", 32'(rx_valid), 32'h0);

    // Short left word discards its frame; next frame is clean
    take_base();
    put_word(1'b0, 8'h5A, 7);
    put_word(1'b1, 8'h99, 8);
    send_frame(8'h0F, 8'hF0);
    close_frame();
    settle();
    check("short_frame_err", 32'(ferr_cnt - b_ferr), 32'd1);
    check("short_count", 32'(acc_q.size() - b_acc), 32'd1);
    check("short_next_data", 32'(get_acc(b_acc)), 32'h0FF0);
    check("short_overrun", 32'(ovr_cnt - b_ovr), 32'd0);

    // Reset in the middle of a right word
    rx_ready = 1'b0;
    send_frame(8'h12, 8'h34);
    put_word(1'b0, 8'hC3, 8);
    put_word(1'b1, 8'h0A, 4);
    check("pre_rst_valid", 32'(rx_valid), 32'h1);
    check("pre_rst_data", 32'(rx_data), 32'h1234);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_data", 32'(rx_data), 32'h0);
    check("mid_rst_valid", 32'(rx_valid), 32'h0);
    check("mid_rst_flags", 32'({overrun, frame_err}), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rx_ready = 1'b1;
    take_base();
    put_word(1'b1, 8'h05, 4);
    send_frame(8'hC3, 8'h81);
    close_frame();
    settle();
    check("after_rst_count", 32'(acc_q.size() - b_acc), 32'd1);
    check("after_rst_data", 32'(get_acc(b_acc)), 32'hC381);
    check("after_rst_frame_err", 32'(ferr_cnt - b_ferr), 32'd0);

    // New frame lands on the cycle the held frame is accepted
    rx_ready = 1'b0;
    take_base();
    send_frame(8'hDE, 8'hAD);
    send_frame(8'hBE, 8'hEF);
    SCLK = 1'b0;
    WS   = 1'b0;
    SD   = sd_delay;
    repeat (half) @(posedge clk);
    #1 SCLK = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("same_cycle_valid", 32'(rx_valid), 32'h1);
    check("same_cycle_data", 32'(rx_data), 32'hBEEF);
    check("same_cycle_overrun", 32'(overrun), 32'h0);
    primed = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("same_cycle_count", 32'(acc_q.size() - b_acc), 32'd2);
    check("same_cycle_first", 32'(get_acc(b_acc)), 32'hDEAD);
    check("same_cycle_second", 32'(get_acc(b_acc + 1)), 32'hBEEF);
    check("same_cycle_ovr_total", 32'(ovr_cnt - b_ovr), 32'd0);

    // Loopback at SCLK = clk/4 with random frames
    half = 2;
    take_base();
    for (int f = 0; f < 6; f++) begin
      fr = 16'($urandom);
      sent_q.push_back(fr);
      send_frame(fr[15:8], fr[7:0]);
    end
    close_frame();
    settle();
    check("loop_count", 32'(acc_q.size() - b_acc), 32'd6);
    for (int i = 0; i < 6; i++) check("loop_data", 32'(get_acc(b_acc + i)), 32'(sent_q[i]));
    check("loop_frame_err", 32'(ferr_cnt - b_ferr), 32'd0);
    check("loop_overrun", 32'(ovr_cnt - b_ovr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
